// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the Data_Memory line-port arbiter.
// Line geometry defaults are shared with Data_Memory and the dcache.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 256;

    localparam bit PORT_DCACHE = 1'b0;
    localparam bit PORT_AUX    = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// 2-way round-robin winner select from the request vector and last-grant pointer.
// Latency: purely combinational.
// Backpressure: none; losers simply stay requesting.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_vld,
    output logic       o_win,
    output logic [1:0] o_gnt
);

    logic w_win;

    always_comb begin
        w_win = PORT_DCACHE;
        case (i_req)
            2'b01:   w_win = PORT_DCACHE;
            2'b10:   w_win = PORT_AUX;
            // On a tie the port that did not win last time goes first.
            2'b11:   w_win = ~i_last;
            default: w_win = PORT_DCACHE;
        endcase
    end

    assign o_vld = |i_req;
    assign o_win = w_win;
    assign o_gnt = o_vld ? port_onehot(w_win) : 2'b00;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin share of the single Data_Memory line port between dcache (p0) and aux (p1); MEM_ARB_TIMEOUT_EN adds a BUSY watchdog.
// Latency: mem_enable_o one cycle after the grant edge; req_ack_o one cycle after mem_ack_i, followed by one RELEASE cycle.
// Backpressure: requesters hold req_enable_i until their ack; one transaction outstanding, the loser waits.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          req_enable_i,
    input  logic [1:0]          req_write_i,
    input  logic [2*ADDR_W-1:0] req_addr_i,
    input  logic [2*DATA_W-1:0] req_data_i,
    output logic [1:0]          req_ack_o,
    output logic [DATA_W-1:0]   req_data_o,
    output logic                mem_enable_o,
    output logic                mem_write_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_data_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_data_i,
    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic              r_last;
    logic              r_win;
    logic [1:0]        r_req_ack;
    logic [DATA_W-1:0] r_req_data;
    logic              r_mem_enable;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic [1:0]        r_grant;

    logic              w_pick_vld;
    logic              w_pick_win;
    logic [1:0]        w_pick_gnt;
    logic              w_load;
    logic              w_done;
    logic              w_wd_expire;
    logic              w_sel_write;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    mem_arb_rr_pick u_pick (
        .i_req  (req_enable_i),
        .i_last (r_last),
        .o_vld  (w_pick_vld),
        .o_win  (w_pick_win),
        .o_gnt  (w_pick_gnt)
    );

    assign w_sel_write = w_pick_win ? req_write_i[1] : req_write_i[0];
    assign w_sel_addr  = w_pick_win ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
    assign w_sel_data  = w_pick_win ? req_data_i[2*DATA_W-1:DATA_W] : req_data_i[DATA_W-1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i || w_wd_expire) begin
                    w_done      = 1'b1;
                    w_state_nxt = RELEASE;
                end
            end
            // One dead cycle so Data_Memory sees enable low and rearms its latency counter.
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_last       <= PORT_AUX;
            r_win        <= PORT_DCACHE;
            r_req_ack    <= 2'b00;
            r_req_data   <= '0;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_grant      <= 2'b00;
        end else begin
            r_req_ack <= 2'b00;
            if (w_load) begin
                r_win        <= w_pick_win;
                r_grant      <= w_pick_gnt;
                r_mem_enable <= 1'b1;
                r_mem_write  <= w_sel_write;
                r_mem_addr   <= w_sel_addr;
                r_mem_data   <= w_sel_data;
            end
            if (w_done) begin
                r_req_ack    <= port_onehot(r_win);
                // A watchdog completion returns an all-zero line.
                r_req_data   <= mem_ack_i ? mem_data_i : '0;
                r_mem_enable <= 1'b0;
                r_grant      <= 2'b00;
                r_last       <= r_win;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_timeout;

    // Counter holds (BUSY cycle - 1), so expiry lands on the TIMEOUT-th BUSY cycle.
    assign w_wd_expire = (r_state == BUSY) && (r_wd_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_load) begin
                r_wd_cnt <= '0;
            end else if (r_state == BUSY) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_wd_expire && !mem_ack_i) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_wd_expire = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    assign req_ack_o    = r_req_ack;
    assign req_data_o   = r_req_data;
    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign grant_o      = r_grant;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 256-bit Data_Memory line port between the data cache (port 0) and a second line requester (port 1: instruction-cache refill or a flush engine). It sits between the cache controllers and Data_Memory, registers the winning request, forwards the enable/write/ack handshake, and returns the line data to the winner. Arbitration is round-robin, and only one memory transaction is outstanding at a time.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 256, line width
- TIMEOUT, 64, watchdog limit in cycles (only used with MEM_ARB_TIMEOUT_EN)
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- req_enable_i  in  2  per-port request, held until that port's ack
- req_write_i  in  2  per-port 1=write line, 0=read line
- req_addr_i  in  2×ADDR_W  per-port line address, packed {p1,p0}
- req_data_i  in  2×DATA_W  per-port write data, packed {p1,p0}
- req_ack_o  out  2  per-port one-cycle completion pulse
- req_data_o  out  DATA_W  read data, valid while any req_ack_o bit is high
- mem_enable_o  out  1  to Data_Memory enable_i
- mem_write_o  out  1  to Data_Memory write_i
- mem_addr_o  out  ADDR_W  to Data_Memory addr_i
- mem_data_o  out  DATA_W  to Data_Memory data_i
- mem_ack_i  in  1  from Data_Memory ack_o
- mem_data_i  in  DATA_W  from Data_Memory data_o
- grant_o  out  2  one-hot current owner, 00 when idle
- timeout_o  out  1  sticky watchdog error (only with MEM_ARB_TIMEOUT_EN, else tied 0)

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE: if any req_enable_i bit is set, pick the winner, latch its write/addr/data into the mem_* output registers, set grant_o, and go to BUSY.
- Winner selection:
  - A single requester wins.
  - If both request, the port not granted most recently wins.
  - The last-grant pointer resets to "port 1", so port 0 wins the first tie.
- BUSY:
  - mem_enable_o=1, and the mem_* outputs are held constant.
  - Changes on req_* inputs are ignored.
  - On mem_ack_i: pulse req_ack_o[winner] for one cycle, register mem_data_i into req_data_o, drop mem_enable_o, update the pointer, and go to RELEASE.
- RELEASE: exactly one cycle with mem_enable_o=0, so Data_Memory restarts its latency counter. Then go to IDLE.
- Requester contract: deassert req_enable_i in the cycle after it samples req_ack_o, or keep it asserted to issue a new request.
- Write data passes through unmodified. The arbiter does no address decoding.
- mem_ack_i outside BUSY is ignored.
- Reset mid-transaction:
  - All outputs return to 0, state goes to IDLE, the pointer goes to port 1, and timeout_o clears.
  - The in-flight memory transaction is abandoned. The external memory must be reset with the same rst_i.

## Timing
- Reset values: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, req_ack_o=00, req_data_o=0, grant_o=00, timeout_o=0.
- Request sampled in IDLE at edge n, then mem_enable_o=1 from cycle n+1.
- mem_ack_i sampled at edge m, then req_ack_o high for cycle m+1 only, with req_data_o valid in that same cycle.
- RELEASE occupies cycle m+1. The earliest next grant decision is at edge m+2, and the next mem_enable_o rises in cycle m+3.
- Minimum overhead per transaction: 3 cycles beyond the memory latency.
- Back-to-back requests from both ports strictly alternate.
- req_ack_o is never high for both ports in the same cycle.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entry to BUSY and increments every BUSY cycle.
  - If it reaches TIMEOUT without mem_ack_i: set timeout_o (sticky until reset), pulse req_ack_o[winner] with req_data_o=0, and go to RELEASE.
  - mem_ack_i arriving in the same cycle as the limit takes precedence, and timeout_o stays 0.
- MEM_ARB_TIMEOUT_EN undefined: no counter is built, timeout_o is tied 0, and BUSY waits indefinitely.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY, RELEASE)
  - the port index constants PORT_DCACHE=0 and PORT_AUX=1
  - the default ADDR_W/DATA_W constants, shared with Data_Memory and dcache.
- One sub-module, mem_arb_rr_pick: combinational 2-way round-robin winner select from the request vector and the last-grant pointer.
- FSM, output registers and watchdog all live in mem_arbiter.

## Test plan
- Reset held 2 cycles with requests asserted: all outputs 0, and grant_o stays 00 until rst_i=1.
- Port 0 reads 0x0000 alone, with memory latency 10:
  - mem_enable_o rises 1 cycle after the request.
  - req_ack_o=01 one cycle after mem_ack_i.
  - req_data_o = memory[0] line 0x0000_1111…FFFF.
- Both ports request in the same cycle (p0 read 0x0200, p1 write 0x0400): p0 served first, then p1. The memory write of p1 data lands at line 32. RELEASE gap of 1 cycle between them.
- Both ports hold requests continuously for 4 transactions: grant order is 0,1,0,1, and each port sees exactly 2 acks.
- Port 0 changes req_addr_i from 0x0000 to 0x0020 while BUSY: mem_addr_o stays 0x0000 until ack.
- MEM_ARB_TIMEOUT_EN with TIMEOUT=64 and memory ack suppressed: req_ack_o pulses at BUSY cycle 64 with data 0, and timeout_o=1 persists until reset. Build without the macro: no ack, and timeout_o=0 throughout.
